// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Memory end of the core's load/store request/response interface. Accepts a
//   single word-aligned load or byte-masked store, waits WAIT_CYCLES states,
//   performs the access on a word-addressed array and holds the response until
//   the initiator takes it. Array contents survive reset.
//
// Parameters
//   DEPTH        number of 32-bit words
//   WAIT_CYCLES  wait states between acceptance and access (0..15)
//   BASE_ADDR    byte address of word 0 (word aligned)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  request present            req_ready  responder idle, can accept
//   req_write  1 = store, 0 = load        req_addr   byte address
//   req_wdata  store data                 req_wstrb  byte-lane enables
//   rsp_valid  response present           rsp_ready  initiator takes response
//   rsp_rdata  load data (0 for stores/errors)
//   rsp_err    misaligned or out-of-range request
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;

  logic          r_write;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [AW-1:0] r_idx;
  logic          r_err;

  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;

  logic [31:0]   r_mem [DEPTH];

  logic          w_req_ready;
  logic          w_accept;
  logic          w_access;
  logic [29:0]   w_word;
  logic          w_req_err;
  logic [AW-1:0] w_req_idx;

  // Access operands: straight from the request when the access happens on the
  // acceptance edge (WAIT_CYCLES == 0), otherwise from the latched copy.
  logic          w_a_write;
  logic [31:0]   w_a_wdata;
  logic [3:0]    w_a_wstrb;
  logic [AW-1:0] w_a_idx;
  logic          w_a_err;

  // Word offset from the base; relies on BASE_ADDR being word aligned.
  assign w_word    = req_addr[31:2] - BASE_ADDR[31:2];
  assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                     (w_word >= 30'(DEPTH));
  assign w_req_idx = w_word[AW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = reset;
        if (req_valid && reset) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_access    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_a_write = r_write;
    w_a_wdata = r_wdata;
    w_a_wstrb = r_wstrb;
    w_a_idx   = r_idx;
    w_a_err   = r_err;
    if (r_state == S_IDLE) begin
      w_a_write = req_write;
      w_a_wdata = req_wdata;
      w_a_wstrb = req_wstrb;
      w_a_idx   = w_req_idx;
      w_a_err   = w_req_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
        r_idx   <= w_req_idx;
        r_err   <= w_req_err;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_a_err;
        r_rsp_rdata <= (!w_a_err && !w_a_write) ? r_mem[w_a_idx] : '0;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  // No reset on the array; w_access is already blocked while reset is low.
  always_ff @(posedge clk) begin
    if (w_access && w_a_write && !w_a_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_a_wstrb[i]) r_mem[w_a_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Three instances share the clock:
//   index 0 uses WAIT_CYCLES = 1, index 1 uses 0, index 2 uses 3.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wstrb [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [31:0] rd;
  logic        er;
  int unsigned lat;

  dmem_responder #(.DEPTH(32), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_w1 (
    .clk(clk), .reset(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(32), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .clk(clk), .reset(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.DEPTH(32), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut_w3 (
    .clk(clk), .reset(rst_n[2]),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request on instance k. Latency counts edges from (and
  // including) the acceptance edge up to the one after which rsp_valid is
  // seen. With bp > 0 the response is held for bp edges with rsp_ready low.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int unsigned bp,
                      output logic [31:0] rdata, output logic err,
                      output int unsigned latency);
    int unsigned guard;
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = wstrb;
    rsp_ready[k] = (bp == 0);
    guard = 0;
    while (!req_ready[k] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    latency = 1;
    while (!rsp_valid[k] && latency < 40) begin
      @(posedge clk); #1;
      latency++;
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    for (int unsigned i = 0; i < bp; i++) begin
      check("bp_valid", 32'(rsp_valid[k]), 32'd1);
      check("bp_rdata", rsp_rdata[k], rdata);
      check("bp_req_ready", 32'(req_ready[k]), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    check("post_valid", 32'(rsp_valid[k]), 32'd0);
    check("post_req_ready", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;

    // WAIT_CYCLES = 1: store then load back
    xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st8_lat", lat, 32'd2);
    check("st8_err", 32'(er), 32'd0);
    check("st8_rdata", rd, 32'd0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld8_rdata", rd, 32'hDEADBEEF);
    check("ld8_lat", lat, 32'd2);

    // byte strobes
    xfer(0, 1'b1, 32'h10, 32'h11223344, 4'hF, 0, rd, er, lat);
    xfer(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    check("strb_err", 32'(er), 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("strb_rdata", rd, 32'h11BB33DD);

    // errors and zero strobe
    xfer(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, er, lat);
    xfer(0, 1'b0, 32'h6, 32'h0, 4'h0, 0, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);
    xfer(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xfer(0, 1'b1, 32'h0, 32'h12121212, 4'h0, 0, rd, er, lat);
    check("zstrb_err", 32'(er), 32'd0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    check("w0_rdata", rd, 32'h0BADF00D);
    check("w0_err", 32'(er), 32'd0);
    xfer(0, 1'b0, 32'h7C, 32'h0, 4'h0, 0, rd, er, lat);
    check("last_word_err", 32'(er), 32'd0);

    // backpressure
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 5, rd, er, lat);
    check("bp_ld_rdata", rd, 32'hDEADBEEF);

    // WAIT_CYCLES = 0
    xfer(1, 1'b1, 32'h4, 32'h55AA55AA, 4'hF, 0, rd, er, lat);
    check("w0_st_lat", lat, 32'd1);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    check("w0_ld_lat", lat, 32'd1);
    check("w0_ld_rdata", rd, 32'h55AA55AA);

    // WAIT_CYCLES = 3: latency, then aborted store
    xfer(2, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    check("w3_st_lat", lat, 32'd4);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h4;
    req_wdata[2] = 32'h12345678; req_wstrb[2] = 4'hF;
    @(posedge clk); #1;                 // acceptance edge (instance idle)
    req_valid[2] = 1'b0;
    check("abort_accepted", 32'(req_ready[2]), 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready[2]), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    check("abort_ld_rdata", rd, 32'hCAFEF00D);

    // reset while a response is pending drops it at once
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 32'h4;
    rsp_ready[2] = 1'b0;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("resp_pending", 32'(rsp_valid[2]), 32'd1);
    rst_n[2] = 1'b0;
    #1;
    check("resp_drop", 32'(rsp_valid[2]), 32'd0);
    rst_n[2] = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
